// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: cpu, dbg and dm buses for dm_arbiter.
// master = arbiter side, slave = requesters and memory side.
interface dm_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_valid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic          dbg_gnt;
    logic          dbg_valid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_valid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_valid, dbg_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_valid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_valid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin cpu/dbg sharing of single-port dm, IDLE->ACCESS->RESP.
// Optional grant/conflict counters enabled by DM_ARB_STATS_EN.
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]         cpu_gnt_cnt,
    output logic [15:0]         dbg_gnt_cnt,
    output logic [15:0]         conflict_cnt,
`endif
    output logic                busy,
    dm_arbiter_if.master        bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic          last_dbg;
    logic          own_dbg;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic el_cpu, el_dbg, arb, take, pick_dbg;

    assign el_cpu   = bus.cpu_req & ~bus.dbg_lock;
    assign el_dbg   = bus.dbg_req;
    assign arb      = (state != ACCESS);
    assign take     = arb & (el_cpu | el_dbg);
    assign pick_dbg = el_dbg & (~el_cpu | ~last_dbg);

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and access outputs, all decoded from state
    always_comb begin
        state_n       = state;
        busy          = 1'b0;
        bus.cpu_gnt   = 1'b0;
        bus.dbg_gnt   = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.dbg_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state)
            IDLE: begin
                state_n = take ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_n       = RESP;
                busy          = 1'b1;
                bus.cpu_gnt   = ~own_dbg;
                bus.dbg_gnt   = own_dbg;
                bus.mem_we    = lat_we;
                bus.mem_addr  = lat_addr;
                bus.mem_wdata = lat_wdata;
            end
            RESP: begin
                state_n       = take ? ACCESS : IDLE;
                busy          = 1'b1;
                bus.cpu_valid = ~own_dbg;
                bus.dbg_valid = own_dbg;
            end
            default: state_n = IDLE;
        endcase
    end

    // latch winner's request and remember it for round-robin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbg  <= 1'b1;
            own_dbg   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take) begin
            last_dbg  <= pick_dbg;
            own_dbg   <= pick_dbg;
            lat_we    <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
            lat_addr  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
            lat_wdata <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
    end

    // capture read data into the owner's register at the end of ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (state == ACCESS && !lat_we) begin
            if (own_dbg) dbg_rdata_q <= bus.mem_rdata;
            else         cpu_rdata_q <= bus.mem_rdata;
        end
    end

`ifdef DM_ARB_STATS_EN
    // saturating grant and conflict counters, stepped at arbitration edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_gnt_cnt  <= '0;
            dbg_gnt_cnt  <= '0;
            conflict_cnt <= '0;
        end else if (take) begin
            if (pick_dbg && dbg_gnt_cnt != 16'hFFFF)
                dbg_gnt_cnt <= dbg_gnt_cnt + 16'd1;
            if (!pick_dbg && cpu_gnt_cnt != 16'hFFFF)
                cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
            if (el_cpu && el_dbg && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter with a small dm model.
// Stats counters are checked when DM_ARB_STATS_EN is defined.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [31:0] dm [0:15];

`ifdef DM_ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt, conflict_cnt;
`endif

    dm_arbiter_if #(.AW(16), .DW(32)) bus ();

    dm_arbiter #(.AW(16), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef DM_ARB_STATS_EN
        .cpu_gnt_cnt  (cpu_gnt_cnt),
        .dbg_gnt_cnt  (dbg_gnt_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .busy         (busy),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // single-port dm: combinational read, write at rising edge
    assign bus.mem_rdata = dm[bus.mem_addr[3:0]];
    always @(posedge clk) begin
        if (bus.mem_we) dm[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".busy"},  {31'd0, busy}, 32'd0);
        chk({tag, ".gnts"},  {30'd0, bus.cpu_gnt, bus.dbg_gnt}, 32'd0);
        chk({tag, ".vals"},  {30'd0, bus.cpu_valid, bus.dbg_valid}, 32'd0);
        chk({tag, ".we"},    {31'd0, bus.mem_we}, 32'd0);
        chk({tag, ".addr"},  {16'd0, bus.mem_addr}, 32'd0);
        chk({tag, ".wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dm[i] = 32'd0;
        dm[5] = 32'hDEADBEEF;
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        bus.dbg_lock = 0;
        #12;
        chk_idle_outs("reset");
        chk("reset.cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("reset.dbg_rdata", bus.dbg_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single cpu read of dm[5]
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd5;
        tick();
        chk("rd.cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        chk("rd.dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        chk("rd.addr", {16'd0, bus.mem_addr}, 32'd5);
        chk("rd.we", {31'd0, bus.mem_we}, 32'd0);
        chk("rd.busy1", {31'd0, busy}, 32'd1);
        bus.cpu_req = 0;
        tick();
        chk("rd.cpu_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("rd.cpu_gnt0", {31'd0, bus.cpu_gnt}, 32'd0);
        chk("rd.rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("rd.busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("rd.idle_busy", {31'd0, busy}, 32'd0);
        chk("rd.valid0", {31'd0, bus.cpu_valid}, 32'd0);

        // dbg write to addr 9, then cpu read back from RESP
        bus.dbg_req = 1; bus.dbg_we = 1;
        bus.dbg_addr = 16'd9; bus.dbg_wdata = 32'h12345678;
        tick();
        chk("wr.dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        chk("wr.we", {31'd0, bus.mem_we}, 32'd1);
        chk("wr.addr", {16'd0, bus.mem_addr}, 32'd9);
        chk("wr.wdata", bus.mem_wdata, 32'h12345678);
        bus.dbg_req = 0;
        tick();
        chk("wr.dbg_valid", {31'd0, bus.dbg_valid}, 32'd1);
        chk("wr.we_resp", {31'd0, bus.mem_we}, 32'd0);
        chk("wr.dm9", dm[9], 32'h12345678);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd9;
        tick();
        chk("rb.cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        chk("rb.we", {31'd0, bus.mem_we}, 32'd0);
        bus.cpu_req = 0;
        tick();
        chk("rb.cpu_valid", {31'd0, bus.cpu_valid}, 32'd1);
        chk("rb.rdata", bus.cpu_rdata, 32'h12345678);
        tick();

        // contention from reset: cpu, dbg, cpu, dbg
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'd5;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 16'd9;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr.cpu_gnt", {31'd0, bus.cpu_gnt}, {31'd0, g % 2 == 0});
            chk("rr.dbg_gnt", {31'd0, bus.dbg_gnt}, {31'd0, g % 2 == 1});
            tick();
            chk("rr.cpu_valid", {31'd0, bus.cpu_valid}, {31'd0, g % 2 == 0});
            chk("rr.dbg_valid", {31'd0, bus.dbg_valid}, {31'd0, g % 2 == 1});
            chk("rr.gnt_resp", {30'd0, bus.cpu_gnt, bus.dbg_gnt}, 32'd0);
        end
        chk("rr.dbg_rdata", bus.dbg_rdata, 32'h12345678);
        chk("rr.cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);

        // dbg_lock: only dbg is served
        bus.dbg_lock = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("lk.cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
            chk("lk.cpu_valid", {31'd0, bus.cpu_valid}, 32'd0);
            chk("lk.dbg_gnt", {31'd0, bus.dbg_gnt}, {31'd0, c % 2 == 0});
        end
        bus.dbg_req = 0;
        tick();
        chk("lk.idle", {31'd0, busy}, 32'd0);
        chk("lk.cpu_gnt_idle", {31'd0, bus.cpu_gnt}, 32'd0);

        // lock raised during a cpu ACCESS: access completes
        bus.dbg_lock = 0;
        tick();
        chk("lm.cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        bus.dbg_lock = 1;
        tick();
        chk("lm.cpu_valid", {31'd0, bus.cpu_valid}, 32'd1);
        tick();
        chk("lm.no_regrant", {31'd0, bus.cpu_gnt}, 32'd0);
        chk("lm.idle", {31'd0, busy}, 32'd0);
        bus.cpu_req = 0;
        bus.dbg_lock = 0;

        // reset in the middle of a dbg write ACCESS
        bus.dbg_req = 1; bus.dbg_we = 1;
        bus.dbg_addr = 16'd3; bus.dbg_wdata = 32'hAAAA5555;
        tick();
        chk("ra.we", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk_idle_outs("ra");
        chk("ra.cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("ra.dbg_rdata", bus.dbg_rdata, 32'd0);
        tick();
        chk("ra.dm3", dm[3], 32'd0);
        bus.dbg_req = 0; bus.dbg_we = 0;
        @(negedge clk);
        rst = 1'b0;

`ifdef DM_ARB_STATS_EN
        chk("st.rst_cpu", {16'd0, cpu_gnt_cnt}, 32'd0);
        chk("st.rst_conf", {16'd0, conflict_cnt}, 32'd0);
        bus.cpu_we = 0; bus.dbg_we = 0;
        bus.cpu_req = 1; bus.dbg_req = 1;
        repeat (6) tick();
        bus.dbg_req = 0;
        repeat (4) tick();
        bus.cpu_req = 0; bus.dbg_req = 1;
        repeat (4) tick();
        bus.dbg_req = 0;
        tick();
        chk("st.conflict", {16'd0, conflict_cnt}, 32'd3);
        chk("st.cpu_cnt", {16'd0, cpu_gnt_cnt}, 32'd4);
        chk("st.dbg_cnt", {16'd0, dbg_gnt_cnt}, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Arbiter and sequencer for the single-port data memory (dm) in the SISC datapath. It shares dm between two requesters:
- the processor load/store path (cpu), driven by ctrl and the mux16 address select;
- a debug/program-loader port (dbg).

It uses round-robin fairness, a debug lock, and a fixed two-cycle access sequence with registered read data.

Parameters:
AW, 16, address width (matches mux16 output)
DW, 32, data width (matches dm and rf)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  cpu access request, held until cpu_gnt
cpu_we  in  1  cpu write (1) / read (0)
cpu_addr  in  AW  cpu address
cpu_wdata  in  DW  cpu write data
cpu_gnt  out  1  one-cycle grant, cpu access in progress
cpu_valid  out  1  one-cycle pulse, cpu_rdata valid (reads and writes)
cpu_rdata  out  DW  registered read data for cpu
dbg_req  in  1  debug access request
dbg_we  in  1  debug write/read
dbg_addr  in  AW  debug address
dbg_wdata  in  DW  debug write data
dbg_lock  in  1  when high, cpu is never granted
dbg_gnt  out  1  one-cycle grant to dbg
dbg_valid  out  1  one-cycle response pulse to dbg
dbg_rdata  out  DW  registered read data for dbg
mem_addr  out  AW  to dm read/write address
mem_wdata  out  DW  to dm write data
mem_we  out  1  to dm write enable
mem_rdata  in  DW  from dm read data (combinational read)
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, last_winner=dbg (so cpu wins the first contention), all gnt/valid/mem_we/busy=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dbg_rdata=0.
- States:
  - IDLE: arbitrates.
  - ACCESS: memory cycle.
  - RESP: response cycle; arbitrates exactly as IDLE.
- Arbitration (IDLE or RESP, sampled at the rising edge):
  - eligible_cpu = cpu_req & ~dbg_lock; eligible_dbg = dbg_req.
  - One eligible requester: it wins.
  - Both eligible: the requester that is not last_winner wins.
  - Winner's we/addr/wdata are latched into internal registers; last_winner is updated; next state is ACCESS.
  - No eligible requester: IDLE goes to IDLE; RESP goes to IDLE.
- ACCESS (1 cycle):
  - Winner's gnt=1.
  - mem_addr and mem_wdata driven from the latched registers; mem_we = latched we.
  - dm commits the write at the closing edge.
  - At the closing edge, mem_rdata is captured into the winner's rdata register (reads only; rdata holds its value on writes). Next state is RESP.
- RESP (1 cycle): winner's valid=1; mem_we=0; arbitration as above.
- Timing:
  - Latency: req sampled at edge E gives gnt in cycle E+1 and valid in cycle E+2.
  - Sustained throughput: one access per 2 cycles.
- Requester rules:
  - Hold req and request fields stable until gnt is seen.
  - req still high in the RESP cycle is treated as a new request.
  - req dropped before grant is not an error; the request is simply not served.
  - Changing fields before gnt is allowed; values at the arbitration edge are used.
- dbg_lock:
  - Asserted mid-access: the in-flight cpu access completes normally.
  - While dbg_lock is high, cpu_gnt and cpu_valid are never raised for new accesses.
- Other outputs:
  - mem_we is 0 in every state except ACCESS-with-write.
  - gnt/valid are never high for both requesters in the same cycle.
  - busy = (state != IDLE).
- rst asserted in any state: immediate return to reset values. mem_we drops asynchronously, so a write in ACCESS is abandoned and must not commit at the next edge.

Optional Feature:
DM_ARB_STATS_EN
- Defined: adds output ports cpu_gnt_cnt[15:0], dbg_gnt_cnt[15:0], and conflict_cnt[15:0] (arbitration edges with both requests eligible).
  - The counters are saturating at 16'hFFFF and cleared by rst.
  - Each counter increments at the edge entering ACCESS (conflict_cnt at the arbitrating edge).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single cpu read: dm[5]=32'hDEADBEEF; cpu_req=1, cpu_we=0, cpu_addr=5 at edge 0 → cpu_gnt in cycle 1 with mem_addr=5 and mem_we=0; cpu_valid in cycle 2 with cpu_rdata=32'hDEADBEEF; busy in cycles 1–2.
- dbg write then cpu read: dbg writes 32'h12345678 to addr 9 → mem_we=1 only in the ACCESS cycle; then cpu reads addr 9 and gets 32'h12345678.
- Contention from reset, both requesting continuously: grants alternate cpu, dbg, cpu, dbg, one grant every 2 cycles; no overlapping gnt/valid.
- dbg_lock=1 with cpu_req and dbg_req held: only dbg granted; cpu_gnt stays 0. Lock asserted during a cpu ACCESS: that cpu access still produces cpu_valid.
- rst pulsed during a dbg write ACCESS (addr 3, data 32'hAAAA5555, dm[3] previously 0): mem_we drops immediately, dm[3] stays 0, state is IDLE, all outputs are 0.
- With DM_ARB_STATS_EN: 3 contended cycles of arbitration → conflict_cnt=3; 4 cpu and 3 dbg grants → cpu_gnt_cnt=4, dbg_gnt_cnt=3.
